// File: rtl/mips_instr_encoder_if.sv
// Request/write-port bundle for the MIPS instruction encoder.
// master = request source and IM observer, slave = encoder.
interface mips_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, op, rs, rt, rd, imm, target,
    input  in_ready, im_we, im_addr, im_wdata, count, full, err
  );

  modport slave (
    input  in_valid, op, rs, rt, rd, imm, target,
    output in_ready, im_we, im_addr, im_wdata, count, full, err
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and writes
// them sequentially into instruction memory through a registered port.
module mips_instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  mips_instr_encoder_if.slave   bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    OP_ADDU  = 4'd0,
    OP_SUBU  = 4'd1,
    OP_SLT   = 4'd2,
    OP_JR    = 4'd3,
    OP_ORI   = 4'd4,
    OP_LW    = 4'd5,
    OP_SW    = 4'd6,
    OP_BEQ   = 4'd7,
    OP_LUI   = 4'd8,
    OP_J     = 4'd9,
    OP_ADDI  = 4'd10,
    OP_ADDIU = 4'd11,
    OP_JAL   = 4'd12
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_SLT    = 6'b101010;
  localparam logic [5:0] FN_JR     = 6'b001000;

  logic              im_we_q,    im_we_d;
  logic [ADDR_W-1:0] im_addr_q,  im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              full_q,     full_d;
  logic              err_q,      err_d;

  logic        in_ready_c;
  logic        accept_c;
  logic        legal_c;
  logic [31:0] enc_c;

  // Combinational encode of the request fields; legal_c flags ops 0..12.
  always_comb begin
    enc_c   = '0;
    legal_c = 1'b1;
    case (bus.op)
      OP_ADDU:  enc_c = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b0, FN_ADDU};
      OP_SUBU:  enc_c = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b0, FN_SUBU};
      OP_SLT:   enc_c = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b0, FN_SLT};
      OP_JR:    enc_c = {OPC_RTYPE, bus.rs, 15'b0, FN_JR};
      OP_ORI:   enc_c = {OPC_ORI,   bus.rs, bus.rt, bus.imm};
      OP_LW:    enc_c = {OPC_LW,    bus.rs, bus.rt, bus.imm};
      OP_SW:    enc_c = {OPC_SW,    bus.rs, bus.rt, bus.imm};
      OP_BEQ:   enc_c = {OPC_BEQ,   bus.rs, bus.rt, bus.imm};
      OP_LUI:   enc_c = {OPC_LUI,   5'b0,   bus.rt, bus.imm};
      OP_J:     enc_c = {OPC_J,     bus.target};
      OP_ADDI:  enc_c = {OPC_ADDI,  bus.rs, bus.rt, bus.imm};
      OP_ADDIU: enc_c = {OPC_ADDIU, bus.rs, bus.rt, bus.imm};
      OP_JAL:   enc_c = {OPC_JAL,   bus.target};
      default:  legal_c = 1'b0;
    endcase
  end

  assign in_ready_c = ~full_q & ~clear & ~rst;
  assign accept_c   = bus.in_valid & in_ready_c;

  // The count doubles as the write pointer; it never wraps because full
  // blocks further accepts.
  always_comb begin
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    count_d    = count_q;
    full_d     = full_q;
    err_d      = err_q;
    if (clear) begin
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept_c) begin
      if (legal_c) begin
        im_we_d    = 1'b1;
        im_addr_d  = count_q[ADDR_W-1:0];
        im_wdata_d = enc_c;
        count_d    = count_q + CNT_W'(1);
        full_d     = (count_d == CNT_W'(DEPTH));
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.err      = err_q;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Instruction encoder/loader for the single-cycle MIPS core. It accepts symbolic instruction requests (op enum plus fields) over a valid/ready handshake and encodes each into a 32-bit MIPS word. Each encoded word is written sequentially into instruction memory through a registered write port. It is the inverse of the controller's opcode/funct decode, and is used by benches and boot logic to build programs that exercise the same instruction set.

Parameters:
ADDR_W, 10, word-address width of the instruction-memory write port
DEPTH, 1024, number of writable words; must be 1..2^ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous restart: pointer, count and err return to 0
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
op  in  4  0 ADDU, 1 SUBU, 2 SLT, 3 JR, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8 LUI, 9 J, 10 ADDI, 11 ADDIU, 12 JAL; 13-15 illegal
rs, rt, rd  in  5 each  register fields
imm  in  16  immediate / offset
target  in  26  jump target field
im_we  out  1  IM write strobe, one cycle per encoded word
im_addr  out  ADDR_W  IM word address
im_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since reset/clear
full  out  1  count == DEPTH
err  out  1  sticky: an illegal op was consumed

Behaviour:
- Reset (async, rst=1): im_we=0, im_addr=0, im_wdata=0, count=0, full=0, err=0, write pointer=0. in_ready=0 while rst=1.
- in_ready = ~full & ~clear & ~rst (combinational).
- Accept = in_valid & in_ready. Inputs are sampled only on accept. Throughput is one request per cycle.
- Latency: 1 cycle. Accept at edge N gives im_we=1 with im_addr=ptr and im_wdata=encoding during cycle N+1. im_we=0 otherwise. im_addr and im_wdata hold their last values when im_we=0.
- Encodings (shamt=0 always):
  - ADDU/SUBU/SLT: {000000, rs, rt, rd, 00000, funct}, with funct 100001 / 100011 / 101010.
  - JR: {000000, rs, 15'b0, 001000}.
  - ORI 001101, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ADDIU 001001: {opcode, rs, rt, imm}.
  - LUI: {001111, 00000, rt, imm}; rs is ignored.
  - J 000010, JAL 000011: {opcode, target}.
- Legal accept: ptr and count increment by 1 when the write issues. full asserts in the same cycle count reaches DEPTH, and in_ready drops that cycle.
- Illegal op (13-15): the request is consumed (handshake completes), no write, ptr and count unchanged, err=1 from the next cycle. err stays set until rst or clear.
- Full: no further accepts. in_valid is ignored and the request stays pending upstream. ptr never wraps.
- clear: at the next edge, ptr=0, count=0, full=0, err=0, im_we=0. clear dominates any accept attempt in the same cycle; in_ready is already 0, so nothing is lost. If a write issued from the previous cycle's accept is already on the port in the clear cycle, it completes; clear only suppresses accepts.
- rst mid-stream: all state clears immediately and asynchronously, including any pending write (im_we=0 at once).
- Combinational encode from the inputs into the output register; no other pipeline state.

Test Plan:
- Single ops, each accepted in turn → each single-cycle im_we at addresses 0, 1, 2, … in order, with these encodings:
  - ADDU rs=1, rt=2, rd=3 → im_wdata=0x00221821, im_addr=0, count=1.
  - ORI rs=0, rt=1, imm=0x1234 → 0x34011234.
  - LW rs=1, rt=2, imm=4 → 0x8C220004.
  - JR rs=31 → 0x03E00008.
  - J target=0x10 → 0x08000010.
  - JAL target=0x10 → 0x0C000010.
- Back-to-back stream: in_valid held high for 3 cycles → im_we high for 3 consecutive cycles, addresses 0, 1, 2.
- Full: DEPTH=4, hold in_valid with 6 requests → exactly 4 writes at addresses 0-3. full=1 and in_ready=0 from the cycle count=4. Requests 5-6 are not accepted.
- Illegal: op=14 accepted between two ADDUs → writes at addresses 0 and 1 only; err=1 from the cycle after acceptance; count=2.
- clear: after 3 writes, pulse clear with in_valid=1 → no accept that cycle; next cycle count=0, err=0; next accept writes address 0.
- rst asserted asynchronously mid-cycle during a pending write → im_we falls immediately, and all outputs read 0 before the next clock edge.
